// File: rtl/store_buffer.sv
// ---------------------------------------------------------------------------
// store_buffer
//   Write-posting buffer between the MEM stage and a single-ported data
//   memory. Stores are posted in one cycle and written to memory in order,
//   one per cycle, whenever the shared memory address port is not needed by
//   a load. A load whose word index matches a posted store stalls until the
//   matching entries have drained.
//
//   Optional feature (macro STORE_BUFFER_FWD_EN): adds ld_fwd_valid and
//   ld_fwd_data. An lw that exactly matches the youngest matching entry,
//   when that entry is an sw, is forwarded instead of stalled.
//
// Ports
//   clk, rst_n           clock (rising edge), async active-low reset
//   st_valid/st_ready    store handshake
//   st_funct3/addr/data  store payload
//   ld_valid/funct3/addr load presented by MEM this cycle
//   ld_stall             load must be held (address hazard)
//   flush_req            fence: drain regardless of a pending load
//   empty                no posted stores
//   mem_*                shared data-memory port (address, funct3, write)
//   ld_fwd_valid/data    (STORE_BUFFER_FWD_EN only) forwarded load data
// ---------------------------------------------------------------------------
module store_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int IDX_BITS   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [2:0]            st_funct3,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [DATA_WIDTH-1:0] st_data,
  input  logic                  ld_valid,
  input  logic [2:0]            ld_funct3,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_stall,
  input  logic                  flush_req,
  output logic                  empty,
`ifdef STORE_BUFFER_FWD_EN
  output logic                  ld_fwd_valid,
  output logic [DATA_WIDTH-1:0] ld_fwd_data,
`endif
  output logic                  mem_wr_en,
  output logic [2:0]            mem_funct3,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data
);

  localparam int PTR_W = $clog2(DEPTH);

  // Handshake: a store transfers on a rising edge where st_valid && st_ready.
  // st_ready depends only on the registered count, so a full buffer refuses
  // a store even in a cycle where an entry drains.

  logic [2:0]            f3_q   [DEPTH];
  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [DATA_WIDTH-1:0] data_q [DEPTH];

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [PTR_W:0]   count_q, count_d;

  logic             full, push, drain, fwd_hit;
  logic [DEPTH-1:0] ent_valid, ent_match;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (PTR_W+1)'(DEPTH));
  assign st_ready = !full;
  assign push     = st_valid && st_ready;

  // An entry is live when its distance from head is below count.
  always_comb begin
    ent_valid = '0;
    ent_match = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ent_valid[i] = ({1'b0, PTR_W'(i) - head_q} < count_q);
      ent_match[i] = ent_valid[i] &&
                     (ld_addr[IDX_BITS+1:2] == addr_q[i][IDX_BITS+1:2]);
    end
  end

`ifdef STORE_BUFFER_FWD_EN
  logic [PTR_W-1:0] yng_idx;
  logic             yng_hit;

  // Walk oldest to youngest so the last match found is the youngest one.
  always_comb begin
    yng_idx = '0;
    yng_hit = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      if (ent_match[head_q + PTR_W'(k)]) begin
        yng_idx = head_q + PTR_W'(k);
        yng_hit = 1'b1;
      end
    end
  end

  assign fwd_hit = ld_valid && yng_hit && (f3_q[yng_idx] == 3'b010) &&
                   (ld_funct3 == 3'b010) && (addr_q[yng_idx] == ld_addr);
  assign ld_fwd_valid = fwd_hit;
  assign ld_fwd_data  = fwd_hit ? data_q[yng_idx] : '0;
`else
  assign fwd_hit = 1'b0;
`endif

  assign ld_stall = ld_valid && (|ent_match) && !fwd_hit;

  // A non-hazard load owns the port; a stalled load, a fence or an idle
  // load slot lets the head entry write.
  assign drain = !empty && (!ld_valid || ld_stall || flush_req);

  always_comb begin
    if (drain) begin
      mem_wr_en   = 1'b1;
      mem_addr    = addr_q[head_q];
      mem_funct3  = f3_q[head_q];
      mem_wr_data = data_q[head_q];
    end else begin
      mem_wr_en   = 1'b0;
      mem_addr    = ld_addr;
      mem_funct3  = ld_funct3;
      mem_wr_data = '0;
    end
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (drain) head_d = head_q + 1'b1;
    if (push)  tail_d = tail_q + 1'b1;
    case ({push, drain})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payload needs no reset: it is only observed through count.
  always_ff @(posedge clk) begin
    if (push) begin
      f3_q[tail_q]   <= st_funct3;
      addr_q[tail_q] <= st_addr;
      data_q[tail_q] <= st_data;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
module tb_store_buffer;

  localparam int IDX = 6;
  localparam int DEP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        st_valid, st_ready;
  logic [2:0]  st_funct3;
  logic [31:0] st_addr, st_data;
  logic        ld_valid;
  logic [2:0]  ld_funct3;
  logic [31:0] ld_addr;
  logic        ld_stall, flush_req, empty;
  logic        mem_wr_en;
  logic [2:0]  mem_funct3;
  logic [31:0] mem_addr, mem_wr_data;
  logic        ld_fwd_valid;
  logic [31:0] ld_fwd_data;

  store_buffer #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH(DEP), .IDX_BITS(IDX)) dut (
    .clk(clk), .rst_n(rst_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_funct3(st_funct3),
    .st_addr(st_addr), .st_data(st_data),
    .ld_valid(ld_valid), .ld_funct3(ld_funct3), .ld_addr(ld_addr),
    .ld_stall(ld_stall), .flush_req(flush_req), .empty(empty),
`ifdef STORE_BUFFER_FWD_EN
    .ld_fwd_valid(ld_fwd_valid), .ld_fwd_data(ld_fwd_data),
`endif
    .mem_wr_en(mem_wr_en), .mem_funct3(mem_funct3),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data)
  );

`ifndef STORE_BUFFER_FWD_EN
  assign ld_fwd_valid = 1'b0;
  assign ld_fwd_data  = '0;
`endif

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / reference model ----------------
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t mq[$];  // posted stores, oldest at index 0
  logic [31:0] exp_q[$];  // expected write addresses for explicit drain checks

  int n_pass = 0;
  int n_total = 0;

  logic        m_ready, m_empty, m_stall, m_wr, m_fv;
  logic [31:0] m_addr, m_data, m_fd;
  logic [2:0]  m_f3;
  bit          m_drain;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Expected outputs from the queue of posted stores and the current inputs.
  task automatic model_eval();
    bit match;
    int y;
    match = 0;
    y = 0;
    foreach (mq[i])
      if (mq[i].a[IDX+1:2] == ld_addr[IDX+1:2]) begin
        match = 1;
        y = i;
      end
    m_fv = 0;
    m_fd = 0;
`ifdef STORE_BUFFER_FWD_EN
    if (ld_valid && match)
      if (mq[y].f3 == 3'b010 && ld_funct3 == 3'b010 && mq[y].a == ld_addr) begin
        m_fv = 1;
        m_fd = mq[y].d;
      end
`endif
    m_empty = (mq.size() == 0);
    m_ready = (mq.size() < DEP);
    m_stall = ld_valid && match && !m_fv;
    m_drain = !m_empty && (!ld_valid || m_stall || flush_req);
    if (m_drain) begin
      m_wr = 1; m_addr = mq[0].a; m_f3 = mq[0].f3; m_data = mq[0].d;
    end else begin
      m_wr = 0; m_addr = ld_addr; m_f3 = ld_funct3; m_data = 0;
    end
  endtask

  task automatic model_update();
    if (m_drain) mq.delete(0);
    if (st_valid && m_ready) mq.push_back('{f3: st_funct3, a: st_addr, d: st_data});
  endtask

  // ---------------- driver ----------------
  typedef struct {
    logic        sv;
    logic [2:0]  sf3;
    logic [31:0] sa, sd;
    logic        lv;
    logic [2:0]  lf3;
    logic [31:0] la;
    logic        fl;
    logic        e_ready, e_empty, e_stall, e_wr;
    logic [31:0] e_addr;
    logic [2:0]  e_f3;
    logic [31:0] e_data;
  } vec_t;

  function automatic vec_t mk(logic sv, logic [2:0] sf3, logic [31:0] sa, logic [31:0] sd,
                              logic lv, logic [2:0] lf3, logic [31:0] la, logic fl,
                              logic er, logic ee, logic es, logic ew,
                              logic [31:0] ea, logic [2:0] ef, logic [31:0] ed);
    vec_t v;
    v.sv = sv; v.sf3 = sf3; v.sa = sa; v.sd = sd;
    v.lv = lv; v.lf3 = lf3; v.la = la; v.fl = fl;
    v.e_ready = er; v.e_empty = ee; v.e_stall = es; v.e_wr = ew;
    v.e_addr = ea; v.e_f3 = ef; v.e_data = ed;
    return v;
  endfunction

  task automatic drive(input logic sv, input logic [2:0] sf3, input logic [31:0] sa,
                       input logic [31:0] sd, input logic lv, input logic [2:0] lf3,
                       input logic [31:0] la, input logic fl);
    @(negedge clk);
    st_valid = sv; st_funct3 = sf3; st_addr = sa; st_data = sd;
    ld_valid = lv; ld_funct3 = lf3; ld_addr = la; flush_req = fl;
    #1;
    model_eval();
    chk("st_ready", st_ready, m_ready);
    chk("empty", empty, m_empty);
    chk("ld_stall", ld_stall, m_stall);
    chk("mem_wr_en", mem_wr_en, m_wr);
    chk("mem_addr", mem_addr, m_addr);
    chk("mem_funct3", mem_funct3, m_f3);
    chk("mem_wr_data", mem_wr_data, m_data);
`ifdef STORE_BUFFER_FWD_EN
    chk("ld_fwd_valid", ld_fwd_valid, m_fv);
    if (m_fv) chk("ld_fwd_data", ld_fwd_data, m_fd);
`endif
  endtask

  task automatic finish_cycle();
    @(posedge clk);
    model_update();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    finish_cycle();
  endtask

  vec_t tbl[$];

  initial begin
    // ---- reset with a store presented ----
    rst_n = 0;
    st_valid = 1; st_funct3 = 3'b010; st_addr = 32'h10; st_data = 32'h1;
    ld_valid = 0; ld_funct3 = 0; ld_addr = 0; flush_req = 0;
    #2;
    chk("rst_st_ready", st_ready, 1'b1);
    chk("rst_empty", empty, 1'b1);
    chk("rst_mem_wr_en", mem_wr_en, 1'b0);
    chk("rst_ld_stall", ld_stall, 1'b0);
    @(negedge clk);
    st_valid = 0;
    rst_n = 1;
    idle();

    // ---- directed table: post/drain, hazard, aliasing, flush ----
    tbl.push_back(mk(1, 2, 'h10, 'hDEADBEEF, 0, 0, 0, 0,     1, 1, 0, 0, 'h0, 0, 'h0));
    tbl.push_back(mk(1, 0, 'h14, 'hAB, 0, 0, 0, 0,           1, 0, 0, 1, 'h10, 2, 'hDEADBEEF));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                 1, 0, 0, 1, 'h14, 0, 'hAB));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,                 1, 1, 0, 0, 'h0, 0, 'h0));
    tbl.push_back(mk(1, 2, 'h20, 'h11111111, 1, 2, 'h80, 0,  1, 1, 0, 0, 'h80, 2, 'h0));
    tbl.push_back(mk(1, 2, 'h24, 'h22222222, 1, 2, 'h80, 0,  1, 0, 0, 0, 'h80, 2, 'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h24, 0,              1, 0, 1, 1, 'h20, 2, 'h11111111));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h24, 0,              1, 0, 1, 1, 'h24, 2, 'h22222222));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 'h24, 0,              1, 1, 0, 0, 'h24, 1, 'h0));
    tbl.push_back(mk(1, 2, 'h104, 'h33, 0, 0, 0, 0,          1, 1, 0, 0, 'h0, 0, 'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 'h004, 0,             1, 0, 1, 1, 'h104, 2, 'h33));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 'h004, 0,             1, 1, 0, 0, 'h004, 2, 'h0));
    tbl.push_back(mk(1, 2, 'h40, 'h40404040, 1, 2, 'h80, 0,  1, 1, 0, 0, 'h80, 2, 'h0));
    tbl.push_back(mk(1, 2, 'h44, 'h44444444, 1, 2, 'h80, 0,  1, 0, 0, 0, 'h80, 2, 'h0));
    tbl.push_back(mk(1, 2, 'h48, 'h48484848, 1, 2, 'h80, 0,  1, 0, 0, 0, 'h80, 2, 'h0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 'h80, 1,              1, 0, 0, 1, 'h40, 2, 'h40404040));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 'h80, 1,              1, 0, 0, 1, 'h44, 2, 'h44444444));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 'h80, 1,              1, 0, 0, 1, 'h48, 2, 'h48484848));
    tbl.push_back(mk(0, 0, 0, 0, 1, 2, 'h80, 0,              1, 1, 0, 0, 'h80, 2, 'h0));

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].sv, tbl[i].sf3, tbl[i].sa, tbl[i].sd,
            tbl[i].lv, tbl[i].lf3, tbl[i].la, tbl[i].fl);
      chk("tbl_st_ready", st_ready, tbl[i].e_ready);
      chk("tbl_empty", empty, tbl[i].e_empty);
      chk("tbl_ld_stall", ld_stall, tbl[i].e_stall);
      chk("tbl_mem_wr_en", mem_wr_en, tbl[i].e_wr);
      chk("tbl_mem_addr", mem_addr, tbl[i].e_addr);
      chk("tbl_mem_funct3", mem_funct3, tbl[i].e_f3);
      chk("tbl_mem_wr_data", mem_wr_data, tbl[i].e_data);
      finish_cycle();
    end

    // ---- fill to full behind a non-matching load ----
    for (int k = 0; k < DEP; k++) begin
      drive(1, 3'b010, 32'h50 + 32'(4 * k), 32'(k), 1, 3'b010, 32'h80, 0);
      chk("fill_no_write", mem_wr_en, 1'b0);
      exp_q.push_back(32'h50 + 32'(4 * k));
      finish_cycle();
    end
    drive(1, 3'b010, 32'h60, 32'h99, 1, 3'b010, 32'h80, 0);
    chk("full_st_ready", st_ready, 1'b0);
    chk("full_mem_addr", mem_addr, 32'h80);
    chk("full_no_write", mem_wr_en, 1'b0);
    finish_cycle();
    while (exp_q.size() > 0) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("fill_drain_wr", mem_wr_en, 1'b1);
      chk("fill_drain_addr", mem_addr, exp_q.pop_front());
      finish_cycle();
    end
    drive(1, 3'b000, 32'h64, 32'h5, 0, 0, 0, 0);
    chk("refill_ready", st_ready, 1'b1);
    chk("refill_empty", empty, 1'b1);
    finish_cycle();
    idle();

    // ---- async reset in the middle of a drain ----
    for (int k = 0; k < 3; k++) begin
      drive(1, 3'b010, 32'h70 + 32'(4 * k), 32'h7000 + 32'(k), 1, 3'b010, 32'h80, 0);
      finish_cycle();
    end
    idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("mid_drain_wr", mem_wr_en, 1'b1);
    chk("mid_drain_addr", mem_addr, 32'h74);
    rst_n = 0;
    #1;
    chk("rst_drop_wr", mem_wr_en, 1'b0);
    chk("rst_drop_empty", empty, 1'b1);
    mq.delete();
    @(negedge clk);
    rst_n = 1;
    idle();

`ifdef STORE_BUFFER_FWD_EN
    // ---- forwarding ----
    drive(1, 3'b010, 32'h30, 32'h12345678, 0, 0, 0, 0);
    finish_cycle();
    drive(0, 0, 0, 0, 1, 3'b010, 32'h30, 0);
    chk("fwd_valid", ld_fwd_valid, 1'b1);
    chk("fwd_data", ld_fwd_data, 32'h12345678);
    chk("fwd_no_stall", ld_stall, 1'b0);
    chk("fwd_no_write", mem_wr_en, 1'b0);
    finish_cycle();
    drive(0, 0, 0, 0, 1, 3'b000, 32'h30, 0);
    chk("fwd_lb_stall", ld_stall, 1'b1);
    chk("fwd_lb_valid", ld_fwd_valid, 1'b0);
    finish_cycle();
    idle();
`endif

    // ---- randomized traffic against the queue model ----
    for (int n = 0; n < 400; n++) begin
      logic sv, lv, fl;
      logic [2:0] sf3, lf3;
      logic [31:0] sa, la, sd;
      sv  = 1'($urandom_range(0, 1));
      sf3 = 3'($urandom_range(0, 3));
      sa  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
            | 32'($urandom_range(0, 1));
      sd  = $urandom;
      lv  = ($urandom_range(0, 9) < 4);
      lf3 = 3'($urandom_range(0, 2));
      la  = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2)
            | 32'($urandom_range(0, 1));
      fl  = ($urandom_range(0, 9) == 0);
      drive(sv, sf3, sa, sd, lv, lf3, la, fl);
      finish_cycle();
    end
    for (int n = 0; n < DEP + 1; n++) idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("final_empty", empty, 1'b1);
    finish_cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/store_buffer.md
Name: store_buffer

Overview:
- Write-posting buffer between the MEM pipeline stage and the data memory.
- Accepts byte, half and word stores from MEM in one cycle and drains them to data memory in order, one per cycle, when the memory port is free.
- Data memory has a single shared address port: a combinational read and a clocked write both use the same address. This block therefore owns the mux and gives loads priority over draining.
- Detects load/store address hazards against buffered entries and stalls the pipeline until they resolve.

Parameters:
- DATA_WIDTH, 32, store/load data width
- ADDR_WIDTH, 32, byte address width
- DEPTH, 4, buffer entries (power of two, >=2)
- IDX_BITS, 6, word-index bits compared for hazards (addr[IDX_BITS+1:2]; matches 64-word memory aliasing)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- st_valid  in  1  MEM stage presents a store
- st_ready  out  1  buffer can accept a store (= !full)
- st_funct3  in  3  000 sb, 001 sh, 010 sw
- st_addr  in  ADDR_WIDTH  store byte address
- st_data  in  DATA_WIDTH  store data
- ld_valid  in  1  MEM stage presents a load this cycle
- ld_funct3  in  3  load type, passed to memory
- ld_addr  in  ADDR_WIDTH  load byte address
- ld_stall  out  1  load hazard; pipeline holds the load
- flush_req  in  1  fence: drain everything
- empty  out  1  no buffered entries
- mem_wr_en  out  1  data memory write enable
- mem_funct3  out  3  data memory funct3
- mem_addr  out  ADDR_WIDTH  data memory shared address
- mem_wr_data  out  DATA_WIDTH  data memory write data

Behaviour:
- Storage: circular FIFO of DEPTH entries {funct3, addr, data}. Head/tail pointers are log2(DEPTH) bits wide. count is 0..DEPTH. full = (count==DEPTH); empty = (count==0).
- Reset (async, rst_n low): head=tail=count=0, st_ready=1, empty=1, ld_stall=0, mem_wr_en=0. Entry contents are don't-care. A reset mid-drain discards all posted stores.
- Push: st_valid & st_ready at the clock edge writes the entry at tail, tail++, latency 1.
  - st_ready is based on the registered count only. When full, a push is refused even if a drain happens in the same cycle.
  - st_funct3 outside {000,001,010} is still accepted; the memory ignores it.
- Hazard: a load matches an entry when ld_addr[IDX_BITS+1:2] == entry addr[IDX_BITS+1:2] for any valid entry. ld_stall = ld_valid & (any match). Combinational, no funct3 or byte-lane refinement.
- Drain permitted = !empty & (!ld_valid | ld_stall | flush_req).
- Port mux:
  - Drain permitted: mem_addr/mem_funct3/mem_wr_data come from the head entry, mem_wr_en=1, head++ at the edge.
  - Otherwise: mem_addr=ld_addr, mem_funct3=ld_funct3, mem_wr_data=0, mem_wr_en=0.
- Stall resolution: a stalled load drains one entry per cycle until no match remains, then ld_stall falls. Maximum stall is DEPTH cycles.
- flush_req has drain priority over a non-hazard load. The load must also be held during this; the pipeline holds it while !empty.
- Simultaneous push and drain: count unchanged, both pointers advance.
- Push into an empty buffer: the entry is not drainable until the next cycle (no bypass).
- Wrap-around: pointers roll over modulo DEPTH. The FIFO order of writes is preserved exactly.
- A load that does not match while stores are pending reads memory this cycle; the drain waits.

Optional Feature:
- Macro: STORE_BUFFER_FWD_EN.
- Defined: adds output ld_fwd_valid (1) and ld_fwd_data (DATA_WIDTH).
  - When the youngest matching entry is an sw (010), the load is lw (010), and the full byte addresses match: ld_fwd_valid=1, ld_fwd_data = that entry's data, ld_stall=0, and no drain is forced.
  - All other matches stall as above.
- Undefined: these ports are absent and every match stalls.

Test Plan:
- Reset: rst_n low with st_valid=1 -> st_ready=1, empty=1, mem_wr_en=0; after release, no entries exist.
- Post and drain: sw 0x10 data 0xDEADBEEF, then sb 0x14 data 0xAB, ld_valid=0 -> cycle+1 mem_wr_en=1, addr 0x10, funct3 010; cycle+2 addr 0x14, funct3 000; then empty=1.
- Fill to full: 4 pushes with ld_valid held high to non-matching address 0x80 -> st_ready=0 after the 4th; the 5th push is refused; mem_addr=0x80 throughout with no writes. Then drop ld_valid -> 4 in-order writes, pushes accepted again.
- Hazard: buffer holds sw 0x20 and sw 0x24, then load 0x24 -> ld_stall=1 for 2 cycles (0x20 then 0x24 written), falls on cycle 3, and mem_addr=0x24 with funct3 from the load.
- Aliasing: store to 0x104, load 0x004 -> stall (index match). Simultaneous push and drain at count=2 -> count stays 2. Wrap past index DEPTH-1 preserves order.
- Flush and async reset: flush_req with 3 entries and a non-matching ld_valid -> 3 consecutive writes, empty=1. Asserting rst_n low mid-drain -> mem_wr_en drops immediately and the remaining entries are lost.
- Forwarding (macro defined): sw 0x30 data 0x12345678, then lw 0x30 -> ld_fwd_valid=1, data 0x12345678, ld_stall=0. lb 0x30 -> stalls.
